tdm_demux: RTL and testbench

- Time-division demultiplexer: receives a 1-bit serial stream in which CHANNELS channel bits are interleaved slot by slot, plus a frame-sync marker.
- Reconstructs the channels as a registered parallel word.
- Receive-side counterpart of the team's NOR-gate 2:1 selector: the selector merges channels onto one line, this block splits them back out.
- Sits between the serial link and per-channel consumers.

---
 rtl/tdm_pkg.sv | 25 ++
 rtl/tdm_slot_counter.sv | 47 ++++
 rtl/tdm_demux.sv | 140 ++++++++++++++
 tb/tb_tdm_demux.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Build option: define TDM_PARITY_EN to add an even-parity slot to every frame.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

  localparam int unsigned TDM_MAX_CHANNELS = 16;

  function automatic int unsigned frame_len(input int unsigned ch);
`ifdef TDM_PARITY_EN
    return ch + 32'd1;
`else
    return ch;
`endif
  endfunction

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [TDM_MAX_CHANNELS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot counter for the TDM demultiplexer: clear, load-to-1, and increment with wrap at L-1.
// Frame length L follows TDM_PARITY_EN through tdm_pkg::frame_len.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SW       = $clog2(CHANNELS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot,
  output logic          last_slot
);

  localparam logic [SW-1:0] LAST = SW'(frame_len(unsigned'(CHANNELS)) - 32'd1);

  logic [SW-1:0] slot_d;
  logic [SW-1:0] slot_q;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (en) begin
      slot_d = (slot_q == LAST) ? '0 : slot_q + SW'(1);
    end else begin
      slot_d = slot_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot      = slot_q;
  assign last_slot = (slot_q == LAST);

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: splits a serial, frame-synced bit stream into a parallel word.
// Build option: TDM_PARITY_EN appends an even-parity slot that gates each ch_out update.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int SW       = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                din,
  input  logic                sync,
  output logic [CHANNELS-1:0] ch_out,
  output logic                frame_valid,
  output logic                locked,
  output logic                sync_err,
  output logic                parity_err,
  output logic [SW-1:0]       slot
);

  tdm_state_t          state_d, state_q;
  logic [CHANNELS-1:0] shadow_d, shadow_q;
  logic [CHANNELS-1:0] ch_out_d, ch_out_q;
  logic                frame_valid_d, frame_valid_q;
  logic                sync_err_d, sync_err_q;
  logic                parity_err_d, parity_err_q;
  logic                cnt_inc, cnt_load1, cnt_clr;
  logic [SW-1:0]       slot_s;
  logic                last_slot_s;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_inc),
    .load1     (cnt_load1),
    .clr       (cnt_clr),
    .slot      (slot_s),
    .last_slot (last_slot_s)
  );

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    ch_out_d      = ch_out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    parity_err_d  = 1'b0;
    cnt_inc       = 1'b0;
    cnt_load1     = 1'b0;
    cnt_clr       = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d    = '0;
            shadow_d[0] = din;
            cnt_load1   = 1'b1;
            state_d     = LOCKED;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (sync) begin
            // A sync anywhere but slot 0 restarts the frame from this bit.
            sync_err_d  = (slot_s != '0);
            shadow_d    = '0;
            shadow_d[0] = din;
            cnt_load1   = 1'b1;
          end else if (slot_s == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            cnt_clr    = 1'b1;
          end else begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (slot_s == SW'(i)) begin
                shadow_d[i] = din;
              end else begin
                shadow_d[i] = shadow_d[i];
              end
            end
            cnt_inc = 1'b1;
            if (last_slot_s) begin
`ifdef TDM_PARITY_EN
              if (even_parity(TDM_MAX_CHANNELS'(shadow_q)) == din) begin
                ch_out_d      = shadow_q;
                frame_valid_d = 1'b1;
              end else begin
                parity_err_d = 1'b1;
              end
`else
              ch_out_d             = shadow_q;
              ch_out_d[CHANNELS-1] = din;
              frame_valid_d        = 1'b1;
`endif
            end else begin
              frame_valid_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          cnt_clr = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      ch_out_q      <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      ch_out_q      <= ch_out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign ch_out      = ch_out_q;
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;
  assign parity_err  = parity_err_q;
  assign slot        = slot_s;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (CHANNELS=2): directed vector table, hand sequences,
// and randomized traffic against a queue-based frame model. Honours TDM_PARITY_EN.
module tb_tdm_demux;

  localparam int C  = 2;
  localparam int SW = $clog2(C + 1);
`ifdef TDM_PARITY_EN
  localparam int L = C + 1;
`else
  localparam int L = C;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, din = 1'b0, sync = 1'b0;
  logic [C-1:0]  ch_out;
  logic          frame_valid, locked, sync_err, parity_err;
  logic [SW-1:0] slot;

  int n_cmp = 0;
  int n_bad = 0;

  tdm_demux #(.CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
    .ch_out(ch_out), .frame_valid(frame_valid), .locked(locked),
    .sync_err(sync_err), .parity_err(parity_err), .slot(slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en, sync, din;
    logic [C-1:0] ch;
    logic         fv, lk, serr, perr;
    logic [SW-1:0] sl;
  } vec_t;

  // Reference model: a frame is the queue of bits accepted since the last sync.
  bit           m_locked;
  bit           m_buf[$];
  logic [C-1:0] m_ch;
  bit           m_fv, m_serr, m_perr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_buf.delete(); m_ch = '0; m_fv = 0; m_serr = 0; m_perr = 0;
  endtask

  task automatic model_step(input logic e, input logic s, input logic d);
    logic [C-1:0] w;
    m_fv = 0; m_serr = 0; m_perr = 0;
    if (!e) return;
    if (!m_locked) begin
      if (s) begin m_locked = 1; m_buf.delete(); m_buf.push_back(d); end
    end else if (s) begin
      if (m_buf.size() != 0) m_serr = 1;
      m_buf.delete(); m_buf.push_back(d);
    end else if (m_buf.size() == 0) begin
      m_serr = 1; m_locked = 0;
    end else begin
      m_buf.push_back(d);
      if (m_buf.size() == L) begin
        for (int i = 0; i < C; i++) w[i] = m_buf[i];
`ifdef TDM_PARITY_EN
        if ((^w) == m_buf[C]) begin m_ch = w; m_fv = 1; end
        else m_perr = 1;
`else
        m_ch = w; m_fv = 1;
`endif
        m_buf.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ch_out"},      32'(ch_out),      32'(m_ch));
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    check({tag, ".locked"},      32'(locked),      32'(m_locked));
    check({tag, ".sync_err"},    32'(sync_err),    32'(m_serr));
    check({tag, ".parity_err"},  32'(parity_err),  32'(m_perr));
    check({tag, ".slot"},        32'(slot),        32'(m_buf.size()));
  endtask

  task automatic step(input logic e, input logic s, input logic d);
    en = e; sync = s; din = d;
    @(posedge clk); #1;
    model_step(e, s, d);
  endtask

  task automatic run_table(input vec_t v[], input string tag);
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].en, v[i].sync, v[i].din);
      check($sformatf("%s[%0d].ch_out", tag, i),   32'(ch_out),      32'(v[i].ch));
      check($sformatf("%s[%0d].fv", tag, i),       32'(frame_valid), 32'(v[i].fv));
      check($sformatf("%s[%0d].locked", tag, i),   32'(locked),      32'(v[i].lk));
      check($sformatf("%s[%0d].sync_err", tag, i), 32'(sync_err),    32'(v[i].serr));
      check($sformatf("%s[%0d].par_err", tag, i),  32'(parity_err),  32'(v[i].perr));
      check($sformatf("%s[%0d].slot", tag, i),     32'(slot),        32'(v[i].sl));
    end
  endtask

  initial begin
    vec_t tbl[];
    logic s, e, d;
`ifdef TDM_PARITY_EN
    tbl = '{
      '{1'b1,1'b1,1'b1, 2'b00, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b1,1'b0,1'b0, 2'b00, 1'b0,1'b1,1'b0,1'b0, 2'd2},
      '{1'b1,1'b0,1'b1, 2'b01, 1'b1,1'b1,1'b0,1'b0, 2'd0},
      '{1'b1,1'b1,1'b1, 2'b01, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b1,1'b0,1'b1, 2'b01, 1'b0,1'b1,1'b0,1'b0, 2'd2},
      '{1'b1,1'b0,1'b1, 2'b01, 1'b0,1'b1,1'b0,1'b1, 2'd0}
    };
`else
    tbl = '{
      '{1'b1,1'b1,1'b0, 2'b00, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b1,1'b0,1'b1, 2'b10, 1'b1,1'b1,1'b0,1'b0, 2'd0},
      '{1'b1,1'b0,1'b0, 2'b10, 1'b0,1'b0,1'b1,1'b0, 2'd0},
      '{1'b1,1'b0,1'b1, 2'b10, 1'b0,1'b0,1'b0,1'b0, 2'd0},
      '{1'b1,1'b1,1'b1, 2'b10, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b1,1'b0,1'b1, 2'b11, 1'b1,1'b1,1'b0,1'b0, 2'd0},
      '{1'b1,1'b1,1'b0, 2'b11, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b1,1'b1,1'b1, 2'b11, 1'b0,1'b1,1'b1,1'b0, 2'd1},
      '{1'b1,1'b0,1'b0, 2'b01, 1'b1,1'b1,1'b0,1'b0, 2'd0},
      '{1'b1,1'b1,1'b1, 2'b01, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b0,1'b1,1'b0, 2'b01, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b0,1'b0,1'b0, 2'b01, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b0,1'b1,1'b1, 2'b01, 1'b0,1'b1,1'b0,1'b0, 2'd1},
      '{1'b1,1'b0,1'b1, 2'b11, 1'b1,1'b1,1'b0,1'b0, 2'd0},
      '{1'b0,1'b1,1'b1, 2'b11, 1'b0,1'b1,1'b0,1'b0, 2'd0},
      '{1'b0,1'b0,1'b1, 2'b11, 1'b0,1'b1,1'b0,1'b0, 2'd0},
      '{1'b0,1'b1,1'b0, 2'b11, 1'b0,1'b1,1'b0,1'b0, 2'd0}
    };
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    run_table(tbl, "vec");

    // Async reset between edges while mid-frame.
    model_reset();
    m_locked = 1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("mid.slot_before", 32'(slot), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst.ch_out", 32'(ch_out), 32'd0);
    check("arst.locked", 32'(locked), 32'd0);
    check("arst.slot",   32'(slot),   32'd0);
    check("arst.fv",     32'(frame_valid), 32'd0);
    check("arst.serr",   32'(sync_err),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b1);
    check_model("hunt_discard");

    // Randomized traffic, mostly well-framed with occasional framing faults.
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom);
      if ($urandom_range(0, 9) == 0) s = 1'($urandom);
      else s = (m_buf.size() == 0);
      step(e, s, d);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
